// File: rtl/morse_decoder_pkg.sv
// Shared Morse constants: quarter-unit thresholds, FSM states, ASCII codes,
// and the dot/dash bit convention used by the pattern register and the LUT.
package morse_decoder_pkg;

  // Thresholds in quarter-unit ticks (Q counts)
  localparam logic [7:0] Q_GLITCH = 8'd2;
  localparam logic [7:0] Q_DASH   = 8'd8;
  localparam logic [7:0] Q_LETTER = 8'd8;
  localparam logic [7:0] Q_WORD   = 8'd20;
  localparam logic [7:0] Q_STUCK  = 8'd28;
  localparam logic [7:0] Q_MAX    = 8'd255;

  // Pattern storage: low nsym bits hold the symbols, first symbol at bit nsym-1
  localparam int PAT_W  = 6;
  localparam int NSYM_W = 3;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MARK  = 3'd1,
    GAP   = 3'd2,
    WWAIT = 3'd3,
    STUCK = 3'd4
  } state_t;

endpackage

// File: rtl/morse_decoder_if.sv
// Decoder bus: keyed envelope in, decoded character strobe out.
interface morse_decoder_if;
  logic       iKEY;
  logic [7:0] oCHAR;
  logic       oVALID;
  logic       oERR;
  logic       oBUSY;

  // decoder side
  modport master (input iKEY, output oCHAR, oVALID, oERR, oBUSY);
  // key source / character sink side
  modport slave  (output iKEY, input oCHAR, oVALID, oERR, oBUSY);
endinterface

// File: rtl/morse_decoder_lut.sv
// Combinational Morse pattern -> ASCII lookup (A-Z, 0-9).
// pattern holds nsym symbols in its low bits, first symbol at bit nsym-1,
// 1 = dash. Anything not in the table reports hit=0 and ascii='?'.
module morse_lut
  import morse_decoder_pkg::*;
(
  input  logic [NSYM_W-1:0] nsym,
  input  logic [PAT_W-1:0]  pattern,
  output logic [7:0]        ascii,
  output logic              hit
);

  logic [7:0] code;

  // table lookup; code 0 marks a miss
  always_comb begin
    code = 8'h00;
    case ({nsym, pattern})
      {3'd2, 6'b000001}: code = 8'h41; // A .-
      {3'd4, 6'b001000}: code = 8'h42; // B -...
      {3'd4, 6'b001010}: code = 8'h43; // C -.-.
      {3'd3, 6'b000100}: code = 8'h44; // D -..
      {3'd1, 6'b000000}: code = 8'h45; // E .
      {3'd4, 6'b000010}: code = 8'h46; // F ..-.
      {3'd3, 6'b000110}: code = 8'h47; // G --.
      {3'd4, 6'b000000}: code = 8'h48; // H ....
      {3'd2, 6'b000000}: code = 8'h49; // I ..
      {3'd4, 6'b000111}: code = 8'h4A; // J .---
      {3'd3, 6'b000101}: code = 8'h4B; // K -.-
      {3'd4, 6'b000100}: code = 8'h4C; // L .-..
      {3'd2, 6'b000011}: code = 8'h4D; // M --
      {3'd2, 6'b000010}: code = 8'h4E; // N -.
      {3'd3, 6'b000111}: code = 8'h4F; // O ---
      {3'd4, 6'b000110}: code = 8'h50; // P .--.
      {3'd4, 6'b001101}: code = 8'h51; // Q --.-
      {3'd3, 6'b000010}: code = 8'h52; // R .-.
      {3'd3, 6'b000000}: code = 8'h53; // S ...
      {3'd1, 6'b000001}: code = 8'h54; // T -
      {3'd3, 6'b000001}: code = 8'h55; // U ..-
      {3'd4, 6'b000001}: code = 8'h56; // V ...-
      {3'd3, 6'b000011}: code = 8'h57; // W .--
      {3'd4, 6'b001001}: code = 8'h58; // X -..-
      {3'd4, 6'b001011}: code = 8'h59; // Y -.--
      {3'd4, 6'b001100}: code = 8'h5A; // Z --..
      {3'd5, 6'b011111}: code = 8'h30; // 0 -----
      {3'd5, 6'b001111}: code = 8'h31; // 1 .----
      {3'd5, 6'b000111}: code = 8'h32; // 2 ..---
      {3'd5, 6'b000011}: code = 8'h33; // 3 ...--
      {3'd5, 6'b000001}: code = 8'h34; // 4 ....-
      {3'd5, 6'b000000}: code = 8'h35; // 5 .....
      {3'd5, 6'b010000}: code = 8'h36; // 6 -....
      {3'd5, 6'b011000}: code = 8'h37; // 7 --...
      {3'd5, 6'b011100}: code = 8'h38; // 8 ---..
      {3'd5, 6'b011110}: code = 8'h39; // 9 ----.
      default:           code = 8'h00;
    endcase
  end

  assign hit   = (code != 8'h00);
  assign ascii = hit ? code : ASCII_QMARK;

endmodule

// File: rtl/morse_decoder.sv
// Receive-side Morse decoder: synchronises the keyed envelope, times marks
// and spaces in quarter-unit ticks, assembles dot/dash patterns and emits
// one ASCII character (or word space) per one-cycle oVALID strobe.
module morse_decoder
  import morse_decoder_pkg::*;
#(
  parameter int UNIT_CYCLES = 12_500_000,
  parameter int MAX_SYMS    = 6
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  morse_decoder_if.master    bus
);

  localparam int QDIV  = UNIT_CYCLES / 4;
  localparam int PRE_W = (QDIV > 2) ? $clog2(QDIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(QDIV - 1);
  localparam logic [NSYM_W-1:0] NSYM_MAX = NSYM_W'(MAX_SYMS);

  // synchroniser and edge detect
  logic kMeta, kS, kPrev;
  logic kEdge, kRise, kFall;
  logic armed;

  // timebase
  logic [PRE_W-1:0] pre;
  logic [7:0]       q;
  logic             hitLetter, hitWord, hitStuck;

  // character assembly
  state_t            state;
  logic [PAT_W-1:0]  pattern;
  logic [NSYM_W-1:0] nsym;
  logic              ovf;
  logic              spaceOk;
  logic [7:0]        lutChar;
  logic              lutHit;

  // registered outputs
  logic [7:0] chrR;
  logic       validR, errR, busyR;

  // Synchroniser is deliberately not reset so a key held through reset keeps
  // kS high and cannot fake a rising edge after release.
  always_ff @(posedge iCLK) begin
    kMeta <= bus.iKEY;
    kS    <= kMeta;
    kPrev <= kS;
  end

  assign kEdge = kS ^ kPrev;
  assign kRise = kS & ~kPrev;
  assign kFall = ~kS & kPrev;

  // arm only after the key has been seen released
  always_ff @(posedge iCLK) begin
    if (!iRST_N)  armed <= 1'b0;
    else if (!kS) armed <= 1'b1;
  end

  // quarter-unit prescaler and saturating run-length counter, cleared on every edge
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      pre <= '0;
      q   <= '0;
    end else if (kEdge) begin
      pre <= '0;
      q   <= '0;
    end else if (pre == PRE_MAX) begin
      pre <= '0;
      if (q != Q_MAX) q <= q + 8'd1;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // pre wraps to 0 in the same cycle q steps, so this is true exactly once
  // per run: the cycle Q first equals the threshold
  assign hitLetter = (pre == '0) && (q == Q_LETTER);
  assign hitWord   = (pre == '0) && (q == Q_WORD);
  assign hitStuck  = (pre == '0) && (q == Q_STUCK);

  morse_lut uLut (
    .nsym    (nsym),
    .pattern (pattern),
    .ascii   (lutChar),
    .hit     (lutHit)
  );

  // decode FSM with symbol register and registered strobes
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state   <= IDLE;
      pattern <= '0;
      nsym    <= '0;
      ovf     <= 1'b0;
      spaceOk <= 1'b0;
      chrR    <= '0;
      validR  <= 1'b0;
      errR    <= 1'b0;
      busyR   <= 1'b0;
    end else begin
      validR <= 1'b0;
      errR   <= 1'b0;
      case (state)
        IDLE: begin
          if (kRise && armed) begin
            state <= MARK;
            busyR <= 1'b1;
          end
        end

        MARK: begin
          if (kFall) begin
            // short marks are glitches and leave the pattern untouched
            if (q >= Q_GLITCH) begin
              pattern <= {pattern[PAT_W-2:0], (q >= Q_DASH) ? SYM_DASH : SYM_DOT};
              if (nsym == NSYM_MAX) ovf  <= 1'b1;
              else                  nsym <= nsym + NSYM_W'(1);
            end
            state <= GAP;
          end else if (hitStuck) begin
            errR    <= 1'b1;
            pattern <= '0;
            nsym    <= '0;
            ovf     <= 1'b0;
            state   <= STUCK;
          end
        end

        STUCK: begin
          if (!kS) begin
            state <= IDLE;
            busyR <= 1'b0;
          end
        end

        GAP: begin
          if (hitLetter) begin
            if (nsym != '0) begin
              chrR    <= (ovf || !lutHit) ? ASCII_QMARK : lutChar;
              errR    <= ovf || !lutHit;
              validR  <= 1'b1;
              spaceOk <= 1'b1;
              pattern <= '0;
              nsym    <= '0;
              ovf     <= 1'b0;
              state   <= kRise ? MARK : WWAIT;
              busyR   <= 1'b1;
            end else begin
              state <= kRise ? MARK : IDLE;
              busyR <= kRise;
            end
          end else if (kRise) begin
            state <= MARK;
          end
        end

        WWAIT: begin
          if (hitWord) begin
            if (spaceOk) begin
              chrR    <= ASCII_SPACE;
              validR  <= 1'b1;
              spaceOk <= 1'b0;
            end
            state <= kRise ? MARK : IDLE;
            busyR <= kRise;
          end else if (kRise) begin
            state <= MARK;
          end
        end

        default: begin
          state <= IDLE;
          busyR <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oCHAR  = chrR;
  assign bus.oVALID = validR;
  assign bus.oERR   = errR;
  assign bus.oBUSY  = busyR;

endmodule
